// File: rtl/trace_pkg.sv
// rtl/trace_pkg.sv - shared types and widths for the retire trace capture path.
// The record carries a cycle stamp only when TRACE_TIMESTAMP_EN is defined.
package trace_pkg;

    localparam int TRACE_GAP_W = 8;
    localparam int DROP_CNT_W  = 16;

    typedef struct packed {
        logic [31:0]            pc;
        logic [31:0]            ir;
        logic [4:0]             rd;
        logic [31:0]            rd_data;
        logic [TRACE_GAP_W-1:0] gap;
`ifdef TRACE_TIMESTAMP_EN
        logic [31:0]            cycle;
`endif
    } trace_rec_t;

    function automatic logic [DROP_CNT_W-1:0] drop_sat_inc(input logic [DROP_CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/trace_fifo.sv
// rtl/trace_fifo.sv - generic synchronous FIFO with push/pop/count.
// A push into a full FIFO is accepted only when a pop frees the slot in the same cycle.
module trace_fifo #(
    parameter int  DEPTH = 16,
    parameter type T     = logic
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     push_i,
    input  T                         wdata_i,
    input  logic                     pop_i,
    output T                         rdata_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int               PW       = $clog2(DEPTH);
    localparam logic [PW:0]      FULL_CNT = (PW + 1)'(DEPTH);

    T               mem [DEPTH];
    logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PW:0]    count_q,  count_d;
    logic           push_ok;
    logic           pop_ok;

    always_comb begin
        pop_ok   = pop_i && (count_q != '0);
        push_ok  = push_i && ((count_q != FULL_CNT) || pop_ok);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        unique case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset; the pointers and count define what is valid.
    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem[wr_ptr_q] <= wdata_i;
        end
    end

    assign rdata_o = mem[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/trace_capture.sv
// rtl/trace_capture.sv - non-stalling retire snooper buffering trace records for the log sink.
// Optional feature macro: TRACE_TIMESTAMP_EN adds a free-running cycle stamp to each record.
module trace_capture
    import trace_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int GAP_W = TRACE_GAP_W
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  retire_valid_i,
    input  logic [31:0]           retire_pc_i,
    input  logic [31:0]           retire_ir_i,
    input  logic [4:0]            retire_rd_i,
    input  logic [31:0]           retire_rd_data_i,
    output logic                  rec_valid_o,
    input  logic                  rec_ready_i,
    output trace_rec_t            rec_o,
    output logic [DROP_CNT_W-1:0] drop_count_o,
    output logic                  overflow_o
);

    localparam int          CW       = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [CW-1:0]         count;
    logic                  full;
    logic                  pop;
    logic                  push;
    logic                  drop;
    trace_rec_t            wr_rec;

    logic [GAP_W-1:0]      gap_acc_q,    gap_acc_d;
    logic [DROP_CNT_W-1:0] drop_count_q, drop_count_d;
    logic                  overflow_q,   overflow_d;
`ifdef TRACE_TIMESTAMP_EN
    logic [31:0]           cycle_q,      cycle_d;
`endif

    // Full is judged on the registered count; a same-cycle pop makes room for the push.
    always_comb begin
        full = (count == FULL_CNT);
        pop  = rec_valid_o && rec_ready_i;
        push = retire_valid_i && (!full || pop);
        drop = retire_valid_i && full && !pop;
    end

    always_comb begin
        wr_rec         = '0;
        wr_rec.pc      = retire_pc_i;
        wr_rec.ir      = retire_ir_i;
        wr_rec.rd      = retire_rd_i;
        wr_rec.rd_data = retire_rd_data_i;
        wr_rec.gap     = TRACE_GAP_W'(gap_acc_q);
`ifdef TRACE_TIMESTAMP_EN
        wr_rec.cycle   = cycle_q;
`endif
    end

    always_comb begin
        gap_acc_d    = gap_acc_q;
        drop_count_d = drop_count_q;
        overflow_d   = overflow_q;
        if (push) begin
            gap_acc_d = '0;
        end else if (drop) begin
            if (gap_acc_q != '1) begin
                gap_acc_d = gap_acc_q + 1'b1;
            end
            drop_count_d = drop_sat_inc(drop_count_q);
            overflow_d   = 1'b1;
        end
`ifdef TRACE_TIMESTAMP_EN
        cycle_d = cycle_q + 32'd1;
`endif
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            gap_acc_q    <= '0;
            drop_count_q <= '0;
            overflow_q   <= 1'b0;
`ifdef TRACE_TIMESTAMP_EN
            cycle_q      <= '0;
`endif
        end else begin
            gap_acc_q    <= gap_acc_d;
            drop_count_q <= drop_count_d;
            overflow_q   <= overflow_d;
`ifdef TRACE_TIMESTAMP_EN
            cycle_q      <= cycle_d;
`endif
        end
    end

    trace_fifo #(
        .DEPTH (DEPTH),
        .T     (trace_rec_t)
    ) u_fifo (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .push_i  (push),
        .wdata_i (wr_rec),
        .pop_i   (pop),
        .rdata_o (rec_o),
        .count_o (count)
    );

    assign rec_valid_o  = (count != '0);
    assign drop_count_o = drop_count_q;
    assign overflow_o   = overflow_q;

endmodule

// File: tb/tb_trace_capture.sv
// tb/tb_trace_capture.sv - scoreboard bench for trace_capture.
module tb_trace_capture;
    import trace_pkg::*;

    localparam int DEPTH = 16;

    logic                  clk_i = 1'b0;
    logic                  reset_i;
    logic                  retire_valid_i;
    logic [31:0]           retire_pc_i;
    logic [31:0]           retire_ir_i;
    logic [4:0]            retire_rd_i;
    logic [31:0]           retire_rd_data_i;
    logic                  rec_valid_o;
    logic                  rec_ready_i;
    trace_rec_t            rec_o;
    logic [DROP_CNT_W-1:0] drop_count_o;
    logic                  overflow_o;

    trace_capture #(.DEPTH(DEPTH), .GAP_W(TRACE_GAP_W)) dut (
        .clk_i            (clk_i),
        .reset_i          (reset_i),
        .retire_valid_i   (retire_valid_i),
        .retire_pc_i      (retire_pc_i),
        .retire_ir_i      (retire_ir_i),
        .retire_rd_i      (retire_rd_i),
        .retire_rd_data_i (retire_rd_data_i),
        .rec_valid_o      (rec_valid_o),
        .rec_ready_i      (rec_ready_i),
        .rec_o            (rec_o),
        .drop_count_o     (drop_count_o),
        .overflow_o       (overflow_o)
    );

    always #5 clk_i = ~clk_i;

    int                    n_vec = 0;
    int                    n_err = 0;
    trace_rec_t            sb_q[$];
    logic [TRACE_GAP_W-1:0] m_gap;
    logic [DROP_CNT_W-1:0] m_drop;
    logic                  m_ovf;
    logic [31:0]           m_cycle;
    logic [31:0]           next_pc;

    task automatic check_vec(input string tag, input logic [191:0] got, input logic [191:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        sb_q.delete();
        m_gap   = '0;
        m_drop  = '0;
        m_ovf   = 1'b0;
        m_cycle = '0;
    endtask

    task automatic drive(input logic valid, input logic ready);
        retire_valid_i   = valid;
        rec_ready_i      = ready;
        retire_pc_i      = valid ? next_pc : 32'h0;
        retire_ir_i      = $urandom;
        retire_rd_i      = 5'($urandom_range(0, 31));
        retire_rd_data_i = $urandom;
        if (valid) next_pc = next_pc + 32'd4;
    endtask

    // Check outputs mid-cycle, advance the model by one edge, return at the next negedge.
    task automatic tick();
        logic       pop;
        logic       full;
        trace_rec_t r;
        #1;
        check_vec("rec_valid", 192'(rec_valid_o), 192'(sb_q.size() != 0));
        if (sb_q.size() != 0) check_vec("rec", 192'(rec_o), 192'(sb_q[0]));
        check_vec("drop_count", 192'(drop_count_o), 192'(m_drop));
        check_vec("overflow", 192'(overflow_o), 192'(m_ovf));
        pop  = (sb_q.size() != 0) && rec_ready_i;
        full = (sb_q.size() == DEPTH);
        if (pop) void'(sb_q.pop_front());
        if (retire_valid_i) begin
            if (!full || pop) begin
                r         = '0;
                r.pc      = retire_pc_i;
                r.ir      = retire_ir_i;
                r.rd      = retire_rd_i;
                r.rd_data = retire_rd_data_i;
                r.gap     = m_gap;
`ifdef TRACE_TIMESTAMP_EN
                r.cycle   = m_cycle;
`endif
                sb_q.push_back(r);
                m_gap = '0;
            end else begin
                if (m_gap != '1) m_gap = m_gap + 1'b1;
                if (m_drop != '1) m_drop = m_drop + 1'b1;
                m_ovf = 1'b1;
            end
        end
        m_cycle = m_cycle + 32'd1;
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    task automatic drain();
        int guard = 0;
        drive(1'b0, 1'b1);
        while (sb_q.size() != 0 && guard < 64) begin
            tick();
            guard++;
        end
        check_vec("drain_done", 192'(sb_q.size()), 192'(0));
        tick();
    endtask

    initial begin
        next_pc = 32'h100;
        reset_i = 1'b1;
        drive(1'b0, 1'b0);
        model_reset();
        @(negedge clk_i);
        #1;
        check_vec("reset_valid", 192'(rec_valid_o), 192'(0));
        check_vec("reset_drops", 192'(drop_count_o), 192'(0));
        check_vec("reset_ovf", 192'(overflow_o), 192'(0));
        @(negedge clk_i);
        reset_i = 1'b0;
        model_reset();

        // Three in-order retires with the sink ready.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1);
            tick();
        end
        drain();

        // Overflow with sink stalled, then release with one more retire.
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 1'b0);
            tick();
        end
        check_vec("full_count", 192'(sb_q.size()), 192'(DEPTH));
        check_vec("drops_after_20", 192'(drop_count_o), 192'(4));
        drive(1'b1, 1'b1);
        tick();
        drain();

        // Full: simultaneous retire and pop keeps the FIFO full without a drop.
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b1, 1'b0);
            tick();
        end
        drive(1'b1, 1'b1);
        tick();
        drive(1'b1, 1'b0);
        tick();
        drain();

        // Sink ready toggling every cycle under continuous retires.
        for (int i = 0; i < 48; i++) begin
            drive(1'b1, i[0] == 1'b0);
            tick();
        end
        drain();

        // Asynchronous reset between edges while records are buffered.
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b0);
            tick();
        end
        #2;
        reset_i = 1'b1;
        #1;
        model_reset();
        check_vec("async_rst_valid", 192'(rec_valid_o), 192'(0));
        check_vec("async_rst_drops", 192'(drop_count_o), 192'(0));
        check_vec("async_rst_ovf", 192'(overflow_o), 192'(0));
        @(negedge clk_i);
        reset_i = 1'b0;
        model_reset();
        drive(1'b1, 1'b1);
        tick();
        drain();

        // Gap saturation after a long drop run.
        for (int i = 0; i < DEPTH + 300; i++) begin
            drive(1'b1, 1'b0);
            tick();
        end
        check_vec("gap_sat_model", 192'(m_gap), 192'(255));
        drive(1'b1, 1'b1);
        tick();
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
